sc_speed_ctrl: RTL and testbench

SC_SPEED_CTRL -- requirements
Module: sc_speed_ctrl

---
 rtl/sc_speed_ctrl.sv | 71 +++++++
 tb/tb_sc_speed_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/sc_speed_ctrl.sv
// sc_speed_ctrl: IDLE/ACCEL/HOLD/CRASH controller issuing registered upcount and clear-to-zero
// strobes to an external speed counter, with prescaled acceleration and a crash hold-off timer.
module sc_speed_ctrl #(
   parameter int DATAWIDTH = 24,
   parameter int PRESCALE  = 2500000,
   parameter int MAXSPEED  = 15,
   parameter int CRASHHOLD = 50000000
) (
   input  logic                 sc_speed_ctrl_CLOCK_50,
   input  logic                 sc_speed_ctrl_RESET_InHigh,
   input  logic                 sc_speed_ctrl_accel_InLow,
   input  logic                 sc_speed_ctrl_brake_InLow,
   input  logic                 sc_speed_ctrl_crash_InLow,
   input  logic [DATAWIDTH-1:0] sc_speed_ctrl_speed_InBUS,
   output logic                 sc_speed_ctrl_upcount_OutLow,
   output logic                 sc_speed_ctrl_T0_OutLow,
   output logic [1:0]           sc_speed_ctrl_state_OutBUS,
   output logic                 sc_speed_ctrl_atmax_Out
);
   localparam int PW = $clog2(PRESCALE);
   localparam int TW = CRASHHOLD > 1 ? $clog2(CRASHHOLD) : 1;
   localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);
   localparam logic [TW-1:0] TLOAD = TW'(CRASHHOLD - 1);
   localparam logic [DATAWIDTH-1:0] MAXV = DATAWIDTH'(MAXSPEED);
   typedef enum logic [1:0] {IDLE = 2'b00, ACCEL = 2'b01, HOLD = 2'b10, CRASH = 2'b11} state_t;
   state_t st;
   logic [PW-1:0] presc;
   logic [TW-1:0] holdTimer;
   logic accel, brake, crash, belowMax;
   assign accel = !sc_speed_ctrl_accel_InLow;
   assign brake = !sc_speed_ctrl_brake_InLow;
   assign crash = !sc_speed_ctrl_crash_InLow;
   assign belowMax = sc_speed_ctrl_speed_InBUS < MAXV;
   assign sc_speed_ctrl_state_OutBUS = st;
   always_ff @(posedge sc_speed_ctrl_CLOCK_50 or posedge sc_speed_ctrl_RESET_InHigh)
      if (sc_speed_ctrl_RESET_InHigh) begin
         st <= IDLE;
         presc <= '0;
         holdTimer <= '0;
         sc_speed_ctrl_upcount_OutLow <= 1'b1;
         sc_speed_ctrl_T0_OutLow <= 1'b1;
         sc_speed_ctrl_atmax_Out <= 1'b0;
      end else begin
         sc_speed_ctrl_upcount_OutLow <= 1'b1;
         sc_speed_ctrl_T0_OutLow <= 1'b1;
         sc_speed_ctrl_atmax_Out <= !belowMax;
         if (crash) begin
            st <= CRASH;
            holdTimer <= TLOAD;
            sc_speed_ctrl_T0_OutLow <= 1'b0;
         end else if (st == CRASH) begin
            if (holdTimer == '0) st <= IDLE;
            else begin
               holdTimer <= holdTimer - 1'b1;
               sc_speed_ctrl_T0_OutLow <= 1'b0;
            end
         end else if (brake) begin
            st <= IDLE;
            sc_speed_ctrl_T0_OutLow <= 1'b0;
         end else if (st == ACCEL) begin
            if (!accel) st <= HOLD;
            else begin
               presc <= presc == PLAST ? '0 : presc + 1'b1;
               sc_speed_ctrl_upcount_OutLow <= !(presc == PLAST && belowMax);
            end
         end else if (accel) begin
            st <= ACCEL;
            presc <= '0;
         end
      end
endmodule

// File: tb/tb_sc_speed_ctrl.sv
// tb_sc_speed_ctrl: directed scenarios for sc_speed_ctrl with a behavioural speed counter
// fed by the controller's strobes.
module tb_sc_speed_ctrl;
   logic clk = 1'b0, rst = 1'b1;
   logic accel = 1'b1, brake = 1'b1, crash = 1'b1;
   logic [7:0] speed;
   logic up, t0, atmax;
   logic [1:0] st;
   int vecs = 0, miss = 0, overlap = 0;

   sc_speed_ctrl #(.DATAWIDTH(8), .PRESCALE(4), .MAXSPEED(3), .CRASHHOLD(5)) dut (
      .sc_speed_ctrl_CLOCK_50(clk),
      .sc_speed_ctrl_RESET_InHigh(rst),
      .sc_speed_ctrl_accel_InLow(accel),
      .sc_speed_ctrl_brake_InLow(brake),
      .sc_speed_ctrl_crash_InLow(crash),
      .sc_speed_ctrl_speed_InBUS(speed),
      .sc_speed_ctrl_upcount_OutLow(up),
      .sc_speed_ctrl_T0_OutLow(t0),
      .sc_speed_ctrl_state_OutBUS(st),
      .sc_speed_ctrl_atmax_Out(atmax)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge rst)
      if (rst) speed <= '0;
      else if (!t0) speed <= '0;
      else if (!up) speed <= speed + 8'd1;

   always @(negedge clk) if (!up && !t0) overlap++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL reset_state: got %b want 00", st); end
      vecs++; if (up !== 1'b1) begin miss++; $display("FAIL reset_up: got %b want 1", up); end
      vecs++; if (t0 !== 1'b1) begin miss++; $display("FAIL reset_t0: got %b want 1", t0); end
      vecs++; if (atmax !== 1'b0) begin miss++; $display("FAIL reset_atmax: got %b want 0", atmax); end
      rst = 1'b0;
      tick();
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL post_reset_state: got %b want 00", st); end
   endtask

   task automatic test_accel();
      logic e;
      accel = 1'b0;
      tick();
      vecs++; if (st !== 2'b01) begin miss++; $display("FAIL accel_entry: got %b want 01", st); end
      for (int k = 1; k <= 16; k++) begin
         tick();
         e = (k == 4 || k == 8 || k == 12) ? 1'b0 : 1'b1;
         vecs++; if (up !== e) begin miss++; $display("FAIL accel_up k=%0d: got %b want %b", k, up, e); end
      end
      vecs++; if (speed !== 8'd3) begin miss++; $display("FAIL accel_speed: got %0d want 3", speed); end
      vecs++; if (atmax !== 1'b1) begin miss++; $display("FAIL accel_atmax: got %b want 1", atmax); end
      vecs++; if (st !== 2'b01) begin miss++; $display("FAIL accel_stay: got %b want 01", st); end
      accel = 1'b1;
      tick();
      vecs++; if (st !== 2'b10) begin miss++; $display("FAIL accel_hold: got %b want 10", st); end
      brake = 1'b0;
      tick();
      brake = 1'b1;
      tick();
      vecs++; if (speed !== 8'd0) begin miss++; $display("FAIL accel_cleanup_speed: got %0d want 0", speed); end
   endtask

   task automatic test_partial();
      logic e;
      accel = 1'b0;
      for (int k = 0; k <= 5; k++) begin
         tick();
         e = (k == 4) ? 1'b0 : 1'b1;
         vecs++; if (up !== e) begin miss++; $display("FAIL partial_up k=%0d: got %b want %b", k, up, e); end
      end
      accel = 1'b1;
      tick();
      vecs++; if (st !== 2'b10) begin miss++; $display("FAIL partial_hold: got %b want 10", st); end
      vecs++; if (up !== 1'b1) begin miss++; $display("FAIL partial_exit_up: got %b want 1", up); end
      repeat (3) tick();
      vecs++; if (speed !== 8'd1) begin miss++; $display("FAIL partial_retain: got %0d want 1", speed); end
      vecs++; if (up !== 1'b1) begin miss++; $display("FAIL partial_hold_up: got %b want 1", up); end
      accel = 1'b0;
      tick();
      vecs++; if (st !== 2'b01) begin miss++; $display("FAIL partial_reentry: got %b want 01", st); end
      for (int k = 1; k <= 4; k++) begin
         tick();
         e = (k == 4) ? 1'b0 : 1'b1;
         vecs++; if (up !== e) begin miss++; $display("FAIL reentry_up k=%0d: got %b want %b", k, up, e); end
      end
   endtask

   task automatic test_brake_hold();
      accel = 1'b1;
      tick();
      vecs++; if (st !== 2'b10) begin miss++; $display("FAIL brake_pre_hold: got %b want 10", st); end
      vecs++; if (speed !== 8'd2) begin miss++; $display("FAIL brake_pre_speed: got %0d want 2", speed); end
      brake = 1'b0;
      accel = 1'b0;
      tick();
      vecs++; if (t0 !== 1'b0) begin miss++; $display("FAIL brake_t0: got %b want 0", t0); end
      vecs++; if (up !== 1'b1) begin miss++; $display("FAIL brake_up: got %b want 1", up); end
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL brake_state: got %b want 00", st); end
      brake = 1'b1;
      accel = 1'b1;
      tick();
      vecs++; if (t0 !== 1'b1) begin miss++; $display("FAIL brake_t0_release: got %b want 1", t0); end
      vecs++; if (speed !== 8'd0) begin miss++; $display("FAIL brake_speed: got %0d want 0", speed); end
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL brake_idle: got %b want 00", st); end
   endtask

   task automatic test_crash();
      logic e;
      accel = 1'b0;
      tick();
      repeat (3) tick();
      crash = 1'b0;
      tick();
      crash = 1'b1;
      vecs++; if (st !== 2'b11) begin miss++; $display("FAIL crash_state: got %b want 11", st); end
      vecs++; if (t0 !== 1'b0) begin miss++; $display("FAIL crash_t0: got %b want 0", t0); end
      vecs++; if (up !== 1'b1) begin miss++; $display("FAIL crash_no_strobe: got %b want 1", up); end
      for (int j = 1; j <= 5; j++) begin
         tick();
         if (j == 5) accel = 1'b1;
         e = (j <= 4) ? 1'b0 : 1'b1;
         vecs++; if (t0 !== e) begin miss++; $display("FAIL crash_t0 j=%0d: got %b want %b", j, t0, e); end
         vecs++; if (up !== 1'b1) begin miss++; $display("FAIL crash_up j=%0d: got %b want 1", j, up); end
      end
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL crash_exit: got %b want 00", st); end
      vecs++; if (speed !== 8'd0) begin miss++; $display("FAIL crash_speed: got %0d want 0", speed); end
      tick();
   endtask

   task automatic test_crash_reload();
      logic e;
      crash = 1'b0;
      for (int i = 0; i <= 8; i++) begin
         tick();
         crash = (i == 2) ? 1'b0 : 1'b1;
         e = (i < 8) ? 1'b0 : 1'b1;
         vecs++; if (t0 !== e) begin miss++; $display("FAIL reload_t0 i=%0d: got %b want %b", i, t0, e); end
      end
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL reload_exit: got %b want 00", st); end
   endtask

   task automatic test_reset_crash();
      crash = 1'b0;
      tick();
      crash = 1'b1;
      tick();
      vecs++; if (t0 !== 1'b0) begin miss++; $display("FAIL rc_pre_t0: got %b want 0", t0); end
      #2 rst = 1'b1;
      #1;
      vecs++; if (t0 !== 1'b1) begin miss++; $display("FAIL rc_async_t0: got %b want 1", t0); end
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL rc_async_state: got %b want 00", st); end
      rst = 1'b0;
      tick();
      vecs++; if (st !== 2'b00) begin miss++; $display("FAIL rc_after_state: got %b want 00", st); end
      vecs++; if (up !== 1'b1) begin miss++; $display("FAIL rc_after_up: got %b want 1", up); end
   endtask

   task automatic test_no_overlap();
      vecs++; if (overlap !== 0) begin miss++; $display("FAIL strobe_overlap: got %0d want 0", overlap); end
   endtask

   initial begin
      test_reset();
      test_accel();
      test_partial();
      test_brake_hold();
      test_crash();
      test_crash_reload();
      test_reset_crash();
      test_no_overlap();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
